// File: rtl/bcd_display_scan_if.sv
// Bus between the BCD counter chain and the seven-segment scanner.
// The counter side (master) supplies the packed digits and the load strobe;
// the scanner side (slave) returns the segment/anode drive and status flags.
interface bcd_display_scan_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] bcd_in;
   logic                load;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   an;
   logic                frame_tick;
   logic                pending;

   modport master (
      output bcd_in, load,
      input  seg, an, frame_tick, pending
   );

   modport slave (
      input  bcd_in, load,
      output seg, an, frame_tick, pending
   );
endinterface

// File: rtl/bcd_display_scan.sv
// Multiplexed seven-segment driver for a packed BCD word.
// New values are captured into a shadow register on 'load' and only copied to
// the displayed register at a frame wrap, so a frame never mixes old and new
// digits. Each digit is lit for PRESCALE clocks; anodes are one-hot active low.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is always shown).
module bcd_display_scan #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_display_scan_if.slave bus
);
   localparam int W     = 4 * DIGITS;
   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [PS_W-1:0]   prescaler;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_next;
   logic [W-1:0]      disp;
   logic [W-1:0]      disp_next;
   logic [W-1:0]      shadow;
   logic              pending_q;
   logic              tick;
   logic              wrap;
   logic [3:0]        digit_next;
   logic              blank_next;
   logic [DIGITS-1:0] an_next;
   logic [6:0]        seg_q;
   logic [DIGITS-1:0] an_q;
   logic              frame_tick_q;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h40;
      endcase
      return p;
   endfunction

   // Scan timing: tick ends each digit slot, wrap is the tick that closes a frame;
   // the value committed at a wrap is what digit 0 of the new frame decodes
   always_comb begin
      tick      = (prescaler == PS_LAST);
      wrap      = tick && (idx == IDX_LAST);
      idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      disp_next = (wrap && pending_q) ? shadow : disp;
   end

   // Select the digit that becomes visible after the next tick and its anode pattern
   always_comb begin
      digit_next = '0;
      an_next    = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_next == IDX_W'(k)) begin
            digit_next = disp_next[4*k +: 4];
            an_next[k] = 1'b0;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit above digit 0 is blanked when it and every digit above it are zero
   always_comb begin
      logic all_zero;
      all_zero   = 1'b1;
      blank_next = 1'b0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         all_zero = all_zero && (disp_next[4*k +: 4] == 4'd0);
         if (idx_next == IDX_W'(k)) begin
            blank_next = all_zero;
         end
      end
   end
`else
   assign blank_next = 1'b0;
`endif

   // Prescaler free-runs, wrapping so a tick occurs once every PRESCALE clocks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
      end
   end

   // Scan position and registered segment/anode drive change only on ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= IDX_LAST;
         an_q  <= '1;
         seg_q <= '0;
      end else if (tick) begin
         idx   <= idx_next;
         an_q  <= an_next;
         seg_q <= blank_next ? 7'h00 : decode(digit_next);
      end
   end

   // One-cycle frame marker, high while digit 0 of the new frame is first shown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= wrap;
      end
   end

   // Double buffer: loads land in shadow, the displayed copy follows only at a wrap;
   // a load coinciding with a wrap commits the old shadow and stays pending itself
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp      <= '0;
         shadow    <= '0;
         pending_q <= 1'b0;
      end else begin
         disp <= disp_next;
         if (bus.load) begin
            shadow    <= bus.bcd_in;
            pending_q <= 1'b1;
         end else if (wrap) begin
            pending_q <= 1'b0;
         end
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = frame_tick_q;
   assign bus.pending    = pending_q;
endmodule
